// File: rtl/ocm_amo_initiator.sv
// ocm_amo_initiator
// Core-side initiator for the shared OCM arbiter/BRAM. It takes one pipeline
// memory request and runs it through the OCM req/grant/done handshake. It
// supports plain loads, masked stores and read-modify-write atomics. An
// atomic holds the grant from the read to the write, so it cannot be split.
// The core is stalled through o_busy while a request is in flight.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for i_valid; request fields are latched on acceptance
// REQ   | req raised, waiting for the OCM grant
// RD    | granted; the BRAM samples the read address this cycle
// CAP   | read data valid; capture old value and the AMO result (LW: done)
// WR    | write cycle with done (SW: masked wdata, AMO: full new value)
// RESP  | one-cycle ready/err pulse to the core, OCM released
module ocm_amo_initiator #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_valid,
    input  logic [3:0]           i_op,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [31:0]          i_wdata,
    input  logic [3:0]           i_mask,
    output logic                 o_busy,
    output logic                 o_ready,
    output logic                 o_err,
    output logic [31:0]          o_rdata,
    output logic                 o_ocm_req,
    output logic                 o_ocm_done,
    input  logic                 i_ocm_grant,
    output logic [31:0]          o_ocm_data,
    output logic [3:0]           o_ocm_dm_write,
    input  logic [31:0]          i_ocm_data,
    output logic [ADDR_BITS-1:0] o_ocm_addr
);

    localparam logic [3:0] OP_LW   = 4'd0;
    localparam logic [3:0] OP_SW   = 4'd1;
    localparam logic [3:0] OP_SWAP = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MIN  = 4'd7;
    localparam logic [3:0] OP_MAX  = 4'd8;
    localparam logic [3:0] OP_MINU = 4'd9;
    localparam logic [3:0] OP_MAXU = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [3:0]             r_op;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [31:0]            r_wdata;
    logic [3:0]             r_mask;
    logic                   r_err;
    logic [31:0]            r_new;
    logic [31:0]            r_old;
    logic [31:0]            r_rdata;

    logic                   w_legal;
    logic                   w_accept;
    logic [31:0]            w_old;
    logic [31:0]            w_new;
    logic                   w_req;
    logic                   w_done;
    logic [3:0]             w_dm_write;
    logic [31:0]            w_data;

    assign w_legal  = (i_op <= OP_MAXU);
    assign w_accept = (r_state == S_IDLE) && i_valid;

    // BRAM returns bytes in the opposite order to the core view.
    assign w_old = {i_ocm_data[7:0], i_ocm_data[15:8],
                    i_ocm_data[23:16], i_ocm_data[31:24]};

    // AMO result from the freshly read old value (A) and the operand (B).
    always_comb begin
        w_new = w_old;
        case (r_op)
            OP_SWAP: w_new = r_wdata;
            OP_ADD:  w_new = w_old + r_wdata;
            OP_AND:  w_new = w_old & r_wdata;
            OP_OR:   w_new = w_old | r_wdata;
            OP_XOR:  w_new = w_old ^ r_wdata;
            OP_MIN:  w_new = ($signed(w_old) < $signed(r_wdata)) ? w_old : r_wdata;
            OP_MAX:  w_new = ($signed(w_old) > $signed(r_wdata)) ? w_old : r_wdata;
            OP_MINU: w_new = (w_old < r_wdata) ? w_old : r_wdata;
            OP_MAXU: w_new = (w_old > r_wdata) ? w_old : r_wdata;
            default: w_new = w_old;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Grant is only looked at in REQ; afterwards the OCM
    // keeps it until done, so RD..WR needs no further checks.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_state_nxt = w_legal ? S_REQ : S_RESP;
                end
            end
            S_REQ: begin
                if (i_ocm_grant) begin
                    w_state_nxt = (r_op == OP_SW) ? S_WR : S_RD;
                end
            end
            S_RD:    w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = (r_op == OP_LW) ? S_RESP : S_WR;
            S_WR:    w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // OCM-side and core-side outputs decoded from the current state.
    always_comb begin
        w_req      = 1'b0;
        w_done     = 1'b0;
        w_dm_write = 4'h0;
        w_data     = 32'h0;
        o_busy     = 1'b0;
        o_ready    = 1'b0;
        o_err      = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req  = 1'b1;
                o_busy = 1'b1;
            end
            S_RD: begin
                w_req  = 1'b1;
                o_busy = 1'b1;
            end
            S_CAP: begin
                w_req  = 1'b1;
                w_done = (r_op == OP_LW);
                o_busy = 1'b1;
            end
            S_WR: begin
                w_req  = 1'b1;
                w_done = 1'b1;
                o_busy = 1'b1;
                if (r_op == OP_SW) begin
                    w_dm_write = r_mask;
                    w_data     = r_wdata;
                end else begin
                    w_dm_write = 4'hF;
                    w_data     = r_new;
                end
            end
            S_RESP: begin
                o_busy  = 1'b1;
                o_ready = 1'b1;
                o_err   = r_err;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    assign o_ocm_req      = w_req;
    assign o_ocm_done     = w_done;
    assign o_ocm_dm_write = w_dm_write;
    assign o_ocm_data     = w_data;
    assign o_ocm_addr     = w_req ? r_addr : '0;
    assign o_rdata        = r_rdata;

    // Request fields are latched once, on acceptance in IDLE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_op    <= 4'h0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_mask  <= 4'h0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_op    <= i_op;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_mask  <= i_mask;
            r_err   <= ~w_legal;
        end
    end

    // Old value and AMO result are captured while the read data is valid.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_old <= 32'h0;
            r_new <= 32'h0;
        end else if (r_state == S_CAP) begin
            r_old <= w_old;
            r_new <= w_new;
        end
    end

    // Result register only changes on entry to RESP, so it holds between ops.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rdata <= 32'h0;
        end else if (w_state_nxt == S_RESP) begin
            case (r_state)
                S_CAP:   r_rdata <= w_old;
                S_WR:    r_rdata <= (r_op == OP_SW) ? 32'h0 : r_old;
                default: r_rdata <= 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_ocm_amo_initiator.sv
// Bench for ocm_amo_initiator: two initiators share a behavioural OCM
// (registered round-robin grant held until done, BRAM with byte-swapped
// read data). Expected results are queued when a request is driven and
// compared when the initiator raises o_ready.
module tb_ocm_amo_initiator;

    localparam int AB = 12;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;

    logic          valid [2];
    logic [3:0]    op    [2];
    logic [AB-1:0] addr  [2];
    logic [31:0]   wdata [2];
    logic [3:0]    mask  [2];
    logic          busy  [2];
    logic          ready [2];
    logic          err   [2];
    logic [31:0]   rdata [2];
    logic          req   [2];
    logic          done  [2];
    logic [31:0]   odata [2];
    logic [3:0]    dmw   [2];
    logic [AB-1:0] oaddr [2];
    logic          grant [2];
    logic          last;
    logic [31:0]   bram_q;
    logic [31:0]   mem [0:(1<<AB)-1];

    int            n_total = 0;
    int            n_bad   = 0;
    int            done_cnt [2];
    int            req_cnt  [2];
    int            viol;
    logic          p_req  [2];
    logic          p_done [2];

    typedef struct {
        logic [31:0] rd;
        logic        rd_chk;
        logic        er;
        int          lat;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    ocm_amo_initiator #(.ADDR_BITS(AB)) u_dut0 (
        .clk(clk), .nrst(nrst),
        .i_valid(valid[0]), .i_op(op[0]), .i_addr(addr[0]),
        .i_wdata(wdata[0]), .i_mask(mask[0]),
        .o_busy(busy[0]), .o_ready(ready[0]), .o_err(err[0]), .o_rdata(rdata[0]),
        .o_ocm_req(req[0]), .o_ocm_done(done[0]), .i_ocm_grant(grant[0]),
        .o_ocm_data(odata[0]), .o_ocm_dm_write(dmw[0]),
        .i_ocm_data(bram_q), .o_ocm_addr(oaddr[0])
    );

    ocm_amo_initiator #(.ADDR_BITS(AB)) u_dut1 (
        .clk(clk), .nrst(nrst),
        .i_valid(valid[1]), .i_op(op[1]), .i_addr(addr[1]),
        .i_wdata(wdata[1]), .i_mask(mask[1]),
        .o_busy(busy[1]), .o_ready(ready[1]), .o_err(err[1]), .o_rdata(rdata[1]),
        .o_ocm_req(req[1]), .o_ocm_done(done[1]), .i_ocm_grant(grant[1]),
        .o_ocm_data(odata[1]), .o_ocm_dm_write(dmw[1]),
        .i_ocm_data(bram_q), .o_ocm_addr(oaddr[1])
    );

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] amo_ref(input int o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2:       return b;
            3:       return a + b;
            4:       return a & b;
            5:       return a | b;
            6:       return a ^ b;
            7:       return ($signed(a) < $signed(b)) ? a : b;
            8:       return ($signed(a) > $signed(b)) ? a : b;
            9:       return (a < b) ? a : b;
            10:      return (a > b) ? a : b;
            default: return a;
        endcase
    endfunction

    // OCM arbiter: registered grant, held until the owner's done.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            grant[0] <= 1'b0;
            grant[1] <= 1'b0;
            last     <= 1'b1;
        end else if (grant[0]) begin
            if (done[0]) grant[0] <= 1'b0;
        end else if (grant[1]) begin
            if (done[1]) grant[1] <= 1'b0;
        end else if (req[0] && (!req[1] || last)) begin
            grant[0] <= 1'b1;
            last     <= 1'b0;
        end else if (req[1]) begin
            grant[1] <= 1'b1;
            last     <= 1'b1;
        end
    end

    // BRAM: memory kept in core byte order, read port returns swapped bytes.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (grant[c] && req[c]) begin
                bram_q <= bswap(mem[oaddr[c]]);
                if (done[c]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (dmw[c][b]) mem[oaddr[c]][8*b +: 8] <= odata[c][8*b +: 8];
                    end
                end
            end
        end
    end

    // Handshake monitor: done/req cycle counts and protocol violations.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (done[c]) done_cnt[c] <= done_cnt[c] + 1;
            if (req[c])  req_cnt[c]  <= req_cnt[c] + 1;
            if (!nrst) begin
                p_req[c]  <= 1'b0;
                p_done[c] <= 1'b0;
            end else begin
                if (p_req[c] && !req[c] && !p_done[c]) viol <= viol + 1;
                if (done[c] && !req[c]) viol <= viol + 1;
                p_req[c]  <= req[c];
                p_done[c] <= done[c];
            end
        end
        if (grant[0] && grant[1]) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input int c, input string tag);
        chk({tag, "_busy"},  busy[c],  0);
        chk({tag, "_ready"}, ready[c], 0);
        chk({tag, "_err"},   err[c],   0);
        chk({tag, "_rdata"}, rdata[c], 0);
        chk({tag, "_req"},   req[c],   0);
        chk({tag, "_done"},  done[c],  0);
        chk({tag, "_data"},  odata[c], 0);
        chk({tag, "_dmw"},   dmw[c],   0);
        chk({tag, "_addr"},  oaddr[c], 0);
    endtask

    // Drive one request, queue its expectation, wait for ready and compare.
    task automatic do_op(input int c, input logic [3:0] o, input logic [AB-1:0] a,
                         input logic [31:0] d, input logic [3:0] m,
                         input logic [31:0] erd, input logic rdc, input logic eer,
                         input int elat, output logic [31:0] got);
        exp_t e;
        int   n;
        int   d0;
        int   r0;
        e = '{erd, rdc, eer, elat};
        if (c == 0) sb0.push_back(e); else sb1.push_back(e);
        @(negedge clk);
        d0 = done_cnt[c];
        r0 = req_cnt[c];
        valid[c] = 1'b1; op[c] = o; addr[c] = a; wdata[c] = d; mask[c] = m;
        @(negedge clk);
        valid[c] = 1'b0; op[c] = 4'h0; addr[c] = '0; wdata[c] = 32'h0; mask[c] = 4'h0;
        n = 1;
        while (!ready[c] && n < 200) begin
            @(negedge clk);
            n++;
        end
        got = rdata[c];
        if (!ready[c]) begin
            chk("ready_timeout", ready[c], 1);
        end else begin
            if (c == 0) e = sb0.pop_front(); else e = sb1.pop_front();
            if (e.rd_chk) chk("rdata", rdata[c], e.rd);
            chk("err", err[c], e.er);
            chk("busy_in_resp", busy[c], 1);
            if (e.lat >= 0) chk("latency", n, e.lat);
            chk("done_pulses", done_cnt[c] - d0, e.er ? 0 : 1);
            if (e.er) chk("illegal_req_cycles", req_cnt[c] - r0, 0);
        end
    endtask

    logic [31:0] a_v, b_v, got_v, sum0, sum1;
    int          n_w;

    initial begin
        for (int c = 0; c < 2; c++) begin
            valid[c] = 1'b0; op[c] = 4'h0; addr[c] = '0; wdata[c] = 32'h0; mask[c] = 4'h0;
            done_cnt[c] = 0; req_cnt[c] = 0;
        end
        viol = 0;
        #2 nrst = 1'b0;
        #1 chk_zero(0, "reset");
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        // store then load back, plus a partial-mask store
        do_op(0, 4'd1, 12'h010, 32'h11223344, 4'hF, 32'h0, 1, 0, 4, got_v);
        chk("sw_mem", mem[12'h010], 32'h11223344);
        do_op(0, 4'd0, 12'h010, 32'h0, 4'h0, 32'h11223344, 1, 0, 5, got_v);
        do_op(0, 4'd1, 12'h010, 32'hAABBCCDD, 4'h3, 32'h0, 1, 0, 4, got_v);
        do_op(0, 4'd0, 12'h010, 32'h0, 4'h0, 32'h1122CCDD, 1, 0, 5, got_v);

        // AMOADD wraps
        do_op(0, 4'd1, 12'h030, 32'h5, 4'hF, 32'h0, 1, 0, 4, got_v);
        do_op(0, 4'd3, 12'h030, 32'hFFFFFFFF, 4'h0, 32'h5, 1, 0, 6, got_v);
        do_op(0, 4'd0, 12'h030, 32'h0, 4'h0, 32'h4, 1, 0, 5, got_v);

        // signed vs unsigned minimum
        do_op(0, 4'd1, 12'h040, 32'h80000000, 4'hF, 32'h0, 1, 0, 4, got_v);
        do_op(0, 4'd7, 12'h040, 32'h1, 4'h0, 32'h80000000, 1, 0, 6, got_v);
        do_op(0, 4'd0, 12'h040, 32'h0, 4'h0, 32'h80000000, 1, 0, 5, got_v);
        do_op(0, 4'd9, 12'h040, 32'h1, 4'h0, 32'h80000000, 1, 0, 6, got_v);
        do_op(0, 4'd0, 12'h040, 32'h0, 4'h0, 32'h1, 1, 0, 5, got_v);

        // every AMO with random operands
        for (int k = 2; k <= 10; k++) begin
            a_v = $urandom;
            b_v = $urandom;
            do_op(0, 4'd1, 12'(12'h100 + k), a_v, 4'hF, 32'h0, 1, 0, 4, got_v);
            do_op(0, 4'(k), 12'(12'h100 + k), b_v, 4'h0, a_v, 1, 0, 6, got_v);
            do_op(0, 4'd0, 12'(12'h100 + k), 32'h0, 4'h0, amo_ref(k, a_v, b_v), 1, 0, 5, got_v);
        end

        // result holds between operations
        repeat (5) @(negedge clk);
        chk("rdata_hold", rdata[0], got_v);

        // illegal op: immediate error response, no OCM traffic
        do_op(0, 4'd12, 12'h010, 32'h12345678, 4'hF, 32'h0, 1, 1, 1, got_v);

        // two cores contending with AMOADD +1
        do_op(0, 4'd1, 12'h020, 32'h0, 4'hF, 32'h0, 1, 0, 4, got_v);
        sum0 = 32'h0;
        sum1 = 32'h0;
        fork
            begin
                logic [31:0] g0;
                for (int i = 0; i < 50; i++) begin
                    do_op(0, 4'd3, 12'h020, 32'h1, 4'h0, 32'h0, 0, 0, -1, g0);
                    sum0 = sum0 + g0;
                end
            end
            begin
                logic [31:0] g1;
                for (int i = 0; i < 50; i++) begin
                    do_op(1, 4'd3, 12'h020, 32'h1, 4'h0, 32'h0, 0, 0, -1, g1);
                    sum1 = sum1 + g1;
                end
            end
        join
        chk("contend_final", mem[12'h020], 32'd100);
        chk("contend_old_sum", sum0 + sum1, 32'd4950);
        chk("protocol_viol", viol, 0);

        // reset during CAP of an AMOSWAP
        do_op(0, 4'd1, 12'h050, 32'h55, 4'hF, 32'h0, 1, 0, 4, got_v);
        @(negedge clk);
        valid[0] = 1'b1; op[0] = 4'd2; addr[0] = 12'h050; wdata[0] = 32'h99;
        @(negedge clk);
        valid[0] = 1'b0;
        n_w = 0;
        while (!grant[0] && n_w < 50) begin
            @(negedge clk);
            n_w++;
        end
        chk("grant_wait", grant[0], 1);
        @(negedge clk);
        @(negedge clk);
        chk("cap_req", req[0], 1);
        chk("cap_done", done[0], 0);
        nrst = 1'b0;
        #1 chk_zero(0, "midrst");
        chk("midrst_mem", mem[12'h050], 32'h55);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        chk("postrst_mem", mem[12'h050], 32'h55);
        do_op(0, 4'd0, 12'h050, 32'h0, 4'h0, 32'h55, 1, 0, 5, got_v);
        chk("protocol_viol_end", viol, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
